// File: rtl/fpnew_pkg.sv
// Shared types and helpers for the fpnew shared-lane arbitration wrappers.
package fpnew_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  // Index width that stays at least one bit wide for single-requester builds.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_fsm_share_arb_rr_pick.sv
// Round-robin pick: first valid index scanning upward from ptr_i with wrap-around.
module fpnew_rr_pick
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0]            valid_i,
  input  logic [idx_width(NumReq)-1:0] ptr_i,
  output logic                         any_valid_o,
  output logic [idx_width(NumReq)-1:0] winner_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  int unsigned idx;

  always_comb begin
    any_valid_o = 1'b0;
    winner_o    = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!any_valid_o && valid_i[idx[IdxW-1:0]]) begin
        any_valid_o = 1'b1;
        winner_o    = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpnew_fsm_share_arb.sv
// Round-robin arbiter sharing one iterative unit among NumReq requesters.
// Optional per-requester grant counters: define FPNEW_ARB_GRANT_CNT_EN.
module fpnew_fsm_share_arb
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned ResultWidth  = 37,
  parameter int unsigned TagWidth     = 4,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*PayloadWidth-1:0] req_data_i,
  input  logic [NumReq*TagWidth-1:0]     req_tag_i,
  output logic                           unit_valid_o,
  input  logic                           unit_ready_i,
  output logic [PayloadWidth-1:0]        unit_data_o,
  input  logic                           unit_valid_i,
  output logic                           unit_ready_o,
  input  logic [ResultWidth-1:0]         unit_result_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [ResultWidth-1:0]         rsp_result_o,
  output logic [TagWidth-1:0]            rsp_tag_o,
  input  logic                           flush_i,
  output logic                           busy_o,
  output logic [idx_width(NumReq)-1:0]   owner_o,
  output logic [NumReq*CntWidth-1:0]     grant_cnt_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  arb_state_e              state_q, state_d;
  logic [IdxW-1:0]         ptr_q, owner_q;
  logic [PayloadWidth-1:0] data_q;
  logic [TagWidth-1:0]     tag_q;
  logic [ResultWidth-1:0]  result_q;

  logic                    any_valid;
  logic [IdxW-1:0]         winner, ptr_nxt;
  logic                    accept, capture, abort;
  logic [PayloadWidth-1:0] sel_data;
  logic [TagWidth-1:0]     sel_tag;

  fpnew_rr_pick #(
    .NumReq (NumReq)
  ) i_rr_pick (
    .valid_i     (req_valid_i),
    .ptr_i       (ptr_q),
    .any_valid_o (any_valid),
    .winner_o    (winner)
  );

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (winner == IdxW'(i)) begin
        sel_data = req_data_i[i*PayloadWidth +: PayloadWidth];
        sel_tag  = req_tag_i[i*TagWidth +: TagWidth];
      end
    end
  end

  // Explicit wrap keeps the pointer in range for non-power-of-two NumReq.
  assign ptr_nxt = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;

  assign abort = flush_i | rst_i;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    unit_valid_o = 1'b0;
    unit_ready_o = 1'b0;
    rsp_valid_o  = '0;
    accept       = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid && !abort) begin
          req_ready_o[winner] = 1'b1;
          accept              = 1'b1;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid_o = !abort;
        if (unit_ready_i) state_d = WAIT;
      end
      WAIT: begin
        unit_ready_o = !abort;
        if (unit_valid_i && !abort) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = !abort;
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q  <= sel_data;
        tag_q   <= sel_tag;
        owner_q <= winner;
        ptr_q   <= ptr_nxt;
      end
      if (capture) result_q <= unit_result_i;
    end
  end

  assign unit_data_o  = data_q;
  assign rsp_result_o = result_q;
  assign rsp_tag_o    = tag_q;
  assign busy_o       = (state_q != IDLE);
  assign owner_o      = owner_q;

`ifdef FPNEW_ARB_GRANT_CNT_EN
  logic [NumReq-1:0][CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (accept && (winner == IdxW'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  assign grant_cnt_o = '0;
`endif

  a_unit_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (unit_valid_o && !unit_ready_i) |=> $stable(unit_data_o));
  a_rsp_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rsp_valid_o));
  a_req_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));

endmodule

// File: tb/tb_fpnew_fsm_share_arb.sv
// Directed bench for fpnew_fsm_share_arb (NumReq=3, CntWidth=2).
module tb_fpnew_fsm_share_arb;

  localparam int unsigned N  = 3;
  localparam int unsigned PW = 64;
  localparam int unsigned RW = 37;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*PW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic            unit_valid_o, unit_ready_i, unit_valid_i, unit_ready_o;
  logic [PW-1:0]   unit_data;
  logic [RW-1:0]   unit_result;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [RW-1:0]   rsp_result;
  logic [TW-1:0]   rsp_tag;
  logic            flush, busy;
  logic [1:0]      owner;
  logic [N*CW-1:0] grant_cnt;

  always #5 clk = ~clk;

  fpnew_fsm_share_arb #(
    .NumReq       (N),
    .PayloadWidth (PW),
    .ResultWidth  (RW),
    .TagWidth     (TW),
    .CntWidth     (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .req_tag_i     (req_tag),
    .unit_valid_o  (unit_valid_o),
    .unit_ready_i  (unit_ready_i),
    .unit_data_o   (unit_data),
    .unit_valid_i  (unit_valid_i),
    .unit_ready_o  (unit_ready_o),
    .unit_result_i (unit_result),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_result_o  (rsp_result),
    .rsp_tag_o     (rsp_tag),
    .flush_i       (flush),
    .busy_o        (busy),
    .owner_o       (owner),
    .grant_cnt_o   (grant_cnt)
  );

  typedef struct {
    logic [N-1:0]  mask;
    int unsigned   win;
    logic [RW-1:0] result;
    int unsigned   lat;
    int unsigned   ustall;
    int unsigned   rstall;
  } op_t;

  op_t           ops [12];
  logic [PW-1:0] rdata [N];
  logic [TW-1:0] rtag  [N];
  int unsigned   exp_cnt [N];
  int unsigned   total = 0;
  int unsigned   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*CW-1:0] exp_cnt_vec();
    logic [N*CW-1:0] v;
    v = '0;
`ifdef FPNEW_ARB_GRANT_CNT_EN
    for (int i = 0; i < int'(N); i++) v[i*CW +: CW] = CW'(exp_cnt[i]);
`endif
    return v;
  endfunction

  task automatic note_grant(input int unsigned w);
    if (exp_cnt[w] < (1 << CW) - 1) exp_cnt[w]++;
  endtask

  // Called at posedge+1 in IDLE; drives one operation through all four states.
  task automatic run_op(input logic [N-1:0] mask, input int unsigned win,
                        input logic [RW-1:0] res, input int unsigned lat,
                        input int unsigned us, input int unsigned rs, input bit complete);
    logic [N-1:0] oh;
    oh = N'(1) << win;
    req_valid = mask;
    #1;
    chk("busy_idle", 64'(busy), 64'd0);
    chk("grant", 64'(req_ready), 64'(oh));
    note_grant(win);
    tick();
    chk("owner", 64'(owner), 64'(win));
    for (int unsigned k = 0; k < us; k++) begin
      unit_ready_i = 1'b0;
      #1;
      chk("uvalid_stall", 64'(unit_valid_o), 64'd1);
      chk("udata_stall", unit_data, rdata[win]);
      chk("no_grant_issue", 64'(req_ready), 64'd0);
      tick();
    end
    unit_ready_i = 1'b1;
    #1;
    chk("uvalid", 64'(unit_valid_o), 64'd1);
    chk("udata", unit_data, rdata[win]);
    tick();
    unit_ready_i = 1'b0;
    for (int unsigned k = 0; k < lat; k++) begin
      #1;
      chk("uready_wait", 64'(unit_ready_o), 64'd1);
      chk("uvalid_off", 64'(unit_valid_o), 64'd0);
      chk("rsp_idle", 64'(rsp_valid), 64'd0);
      tick();
    end
    unit_valid_i = 1'b1;
    unit_result  = res;
    #1;
    chk("uready_cap", 64'(unit_ready_o), 64'd1);
    tick();
    unit_valid_i = 1'b0;
    unit_result  = 37'h15_5555_5555;
    rsp_ready    = ~oh;
    for (int unsigned k = 0; k < rs; k++) begin
      #1;
      chk("rsp_hold", 64'(rsp_valid), 64'(oh));
      chk("rsp_res_hold", 64'(rsp_result), 64'(res));
      chk("no_grant_resp", 64'(req_ready), 64'd0);
      tick();
    end
    if (complete) begin
      rsp_ready = '1;
      #1;
      chk("rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("rsp_result", 64'(rsp_result), 64'(res));
      chk("rsp_tag", 64'(rsp_tag), 64'(rtag[win]));
      chk("no_grant_resp", 64'(req_ready), 64'd0);
      tick();
      rsp_ready = '0;
      #1;
      chk("busy_done", 64'(busy), 64'd0);
      chk("rsp_off", 64'(rsp_valid), 64'd0);
      chk("rsp_res_stable", 64'(rsp_result), 64'(res));
      chk("grant_cnt", 64'(grant_cnt), 64'(exp_cnt_vec()));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rdata[0] = 64'h0000_0000_0000_00A5;
    rdata[1] = 64'hDEAD_BEEF_0000_0001;
    rdata[2] = 64'h8000_0000_0000_00C3;
    rtag[0]  = 4'h3;
    rtag[1]  = 4'hA;
    rtag[2]  = 4'h5;
    for (int i = 0; i < int'(N); i++) exp_cnt[i] = 0;

    //        mask    win  result             lat us rs
    ops[0]  = '{3'b011, 0, 37'h00_0000_0101, 2, 0, 0};
    ops[1]  = '{3'b011, 1, 37'h10_0000_0202, 1, 0, 0};
    ops[2]  = '{3'b011, 0, 37'h00_1234_5678, 3, 0, 0};
    ops[3]  = '{3'b011, 1, 37'h1F_FFFF_FFFF, 0, 0, 0};
    ops[4]  = '{3'b011, 0, 37'h0A_BCDE_F012, 2, 0, 0};
    ops[5]  = '{3'b011, 1, 37'h00_0000_0077, 1, 0, 0};
    ops[6]  = '{3'b001, 0, 37'h00_0000_001F, 5, 0, 0};
    ops[7]  = '{3'b010, 1, 37'h12_3456_789A, 2, 4, 3};
    ops[8]  = '{3'b111, 2, 37'h00_0000_0333, 1, 0, 0};
    ops[9]  = '{3'b111, 0, 37'h01_0000_0444, 0, 1, 1};
    ops[10] = '{3'b101, 2, 37'h00_0000_0555, 1, 0, 0};
    ops[11] = '{3'b110, 1, 37'h08_0000_0666, 2, 0, 0};

    rst          = 1'b1;
    req_valid    = '0;
    req_data     = {rdata[2], rdata[1], rdata[0]};
    req_tag      = {rtag[2], rtag[1], rtag[0]};
    unit_ready_i = 1'b0;
    unit_valid_i = 1'b0;
    unit_result  = '0;
    rsp_ready    = '0;
    flush        = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_unit_valid", 64'(unit_valid_o), 64'd0);
    chk("rst_unit_ready", 64'(unit_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_unit_data", unit_data, 64'd0);
    chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(ops[i].mask, ops[i].win, ops[i].result, ops[i].lat,
             ops[i].ustall, ops[i].rstall, 1'b1);
    end

    // Flush in WAIT with a result arriving the same cycle; ptr is 2 here.
    req_valid = 3'b011;
    #1;
    chk("fl_grant", 64'(req_ready), 64'b001);
    note_grant(0);
    tick();
    unit_ready_i = 1'b1;
    #1;
    chk("fl_uvalid", 64'(unit_valid_o), 64'd1);
    tick();
    unit_ready_i = 1'b0;
    flush        = 1'b1;
    unit_valid_i = 1'b1;
    unit_result  = 37'h0D_EAD0_0001;
    #1;
    chk("fl_uready_forced", 64'(unit_ready_o), 64'd0);
    chk("fl_rsp_forced", 64'(rsp_valid), 64'd0);
    tick();
    unit_valid_i = 1'b0;
    #1;
    chk("fl_idle", 64'(busy), 64'd0);
    chk("fl_req_ready_forced", 64'(req_ready), 64'd0);
    chk("fl_rsp_off", 64'(rsp_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_result_dropped", 64'(rsp_result), 64'(ops[11].result));
    chk("fl_still_idle", 64'(busy), 64'd0);
    run_op(3'b011, 1, 37'h00_0000_0888, 1, 0, 0, 1'b1);

    // Reset while holding a response; pending req2 must not win over req0.
    run_op(3'b010, 1, 37'h00_0000_0999, 1, 0, 1, 1'b0);
    req_valid = '0;
    rsp_ready = '0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(N); i++) exp_cnt[i] = 0;
    req_valid = 3'b101;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_unit_valid", 64'(unit_valid_o), 64'd0);
    chk("mr_unit_ready", 64'(unit_ready_o), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_owner", 64'(owner), 64'd0);
    chk("mr_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("mr_grant_ptr0", 64'(req_ready), 64'b001);
    run_op(3'b101, 0, 37'h00_0000_0AAA, 1, 0, 0, 1'b1);

    // Four more grants to req0 drive its 2-bit counter into saturation.
    for (int i = 0; i < 4; i++) begin
      run_op(3'b001, 0, RW'(37'h100 + i), 0, 0, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
